reg_wb_arbiter: RTL and testbench

Register-file write-back arbiter and sequencer for the multicycle datapath. It shares the single register-bank write port between three requesters: ALU result, memory load and link/exception write. For each granted request it drives the 2-bit `RegDst` destination-select code, the resolved write address, the write data and `RegWrite`, then returns a one-cycle acknowledge. It sits between the control unit's write-back requests and the register-destination mux/register bank.

---
 rtl/reg_wb_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// ----------------------------------------------------------------------------
// reg_wb_arbiter
//
// Write-back arbiter and sequencer for the multicycle datapath. Three
// requesters share the one register-bank write port:
//   - ALU result
//   - memory load
//   - link/exception write
//
// For each granted request the block latches the RegDst code, the resolved
// write address and the write data. It pulses RegWrite for one cycle, then
// pulses that requester's ack for one cycle.
//
// Sequence per request:
//   IDLE (sample/grant) -> WRITE (RegWrite) -> ACK (ack pulse) -> IDLE
//
// Configuration macro: REG_WB_RR_EN
//   - defined: ALU and MEM alternate round-robin on ties.
//   - undefined: fixed priority LINK > MEM > ALU.
//   In both builds LINK always has the highest priority.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   alu_req/alu_dst_rd/alu_rt/alu_rd/alu_data   ALU write-back request
//   alu_ack                         one-cycle write-complete pulse to the ALU
//   mem_req/mem_rt/mem_data         load write-back request (destination rt)
//   mem_ack                         one-cycle write-complete pulse to the load path
//   link_req/link_sel/link_data     link write (sel 0 -> r31, 1 -> r30)
//   link_ack                        one-cycle write-complete pulse to the link path
//   RegDst                          00 rt, 01 rd, 10 r31, 11 r30
//   reg_waddr/reg_wdata/RegWrite    register-bank write port
//   busy                            high in WRITE and ACK
// ----------------------------------------------------------------------------
module reg_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              alu_req,
    input  logic              alu_dst_rd,
    input  logic [ADDR_W-1:0] alu_rt,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ack,

    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_rt,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ack,

    input  logic              link_req,
    input  logic              link_sel,
    input  logic [DATA_W-1:0] link_data,
    output logic              link_ack,

    output logic [1:0]        RegDst,
    output logic [ADDR_W-1:0] reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              RegWrite,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_LINK = 2'd2
    } src_t;

    state_t            r_state;
    state_t            w_next_state;
    src_t              r_winner;
    src_t              w_winner;
    logic              w_any_req;

    logic [1:0]        r_regdst;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic [1:0]        w_regdst;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_any_req = alu_req | mem_req | link_req;

`ifdef REG_WB_RR_EN
    // 1 = MEM wins the next ALU/MEM tie, 0 = ALU wins it.
    logic r_ptr_mem;
`endif

    // ------------------------------------------------------------------
    // Winner selection (only consumed in IDLE)
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first,
    // so no path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        w_winner = SRC_ALU;
        if (link_req) begin
            w_winner = SRC_LINK;
`ifdef REG_WB_RR_EN
        end else if (alu_req && mem_req) begin
            w_winner = r_ptr_mem ? SRC_MEM : SRC_ALU;
        end else if (mem_req) begin
            w_winner = SRC_MEM;
`else
        end else if (mem_req) begin
            w_winner = SRC_MEM;
`endif
        end else if (alu_req) begin
            w_winner = SRC_ALU;
        end
    end

    // Destination code, address and data of the selected requester.
    always_comb begin
        w_regdst = 2'b00;
        w_waddr  = '0;
        w_wdata  = '0;
        case (w_winner)
            SRC_ALU: begin
                w_regdst = alu_dst_rd ? 2'b01 : 2'b00;
                w_waddr  = alu_dst_rd ? alu_rd : alu_rt;
                w_wdata  = alu_data;
            end
            SRC_MEM: begin
                w_regdst = 2'b00;
                w_waddr  = mem_rt;
                w_wdata  = mem_data;
            end
            SRC_LINK: begin
                w_regdst = link_sel ? 2'b11 : 2'b10;
                w_waddr  = link_sel ? ADDR_W'(30) : ADDR_W'(31);
                w_wdata  = link_data;
            end
            default: begin
                w_regdst = 2'b00;
                w_waddr  = '0;
                w_wdata  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  w_next_state = w_any_req ? ST_WRITE : ST_IDLE;
            ST_WRITE: w_next_state = ST_ACK;
            ST_ACK:   w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Grant capture: fields are latched only on the IDLE cycle that grants,
    // so input changes during WRITE/ACK cannot reach the write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_winner <= SRC_ALU;
            r_regdst <= 2'b00;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_winner <= w_winner;
            r_regdst <= w_regdst;
            r_waddr  <= w_waddr;
            r_wdata  <= w_wdata;
        end
    end

`ifdef REG_WB_RR_EN
    // The pointer moves to the other requester after every ALU or MEM grant.
    // LINK grants leave it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr_mem <= 1'b0;
        end else if (r_state == ST_IDLE && w_any_req) begin
            if (w_winner == SRC_ALU) begin
                r_ptr_mem <= 1'b1;
            end else if (w_winner == SRC_MEM) begin
                r_ptr_mem <= 1'b0;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    // Writes to register 0 are dropped at the enable. The FSM still walks
    // WRITE -> ACK so the requester gets its ack.
    always_comb begin
        RegWrite = 1'b0;
        alu_ack  = 1'b0;
        mem_ack  = 1'b0;
        link_ack = 1'b0;
        busy     = 1'b0;
        case (r_state)
            ST_WRITE: begin
                RegWrite = (r_waddr != '0);
                busy     = 1'b1;
            end
            ST_ACK: begin
                alu_ack  = (r_winner == SRC_ALU);
                mem_ack  = (r_winner == SRC_MEM);
                link_ack = (r_winner == SRC_LINK);
                busy     = 1'b1;
            end
            default: begin
                RegWrite = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    assign RegDst    = r_regdst;
    assign reg_waddr = r_waddr;
    assign reg_wdata = r_wdata;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_reg_wb_arbiter
//
// Self-checking bench for reg_wb_arbiter.
//   - A table of single-requester vectors is applied and checked through
//     WRITE, ACK and back to IDLE.
//   - Hand-written sequences cover LINK-over-MEM priority, ALU/MEM
//     contention, and reset during WRITE.
// Expectations for the contention sequence follow REG_WB_RR_EN.
// ----------------------------------------------------------------------------
module tb_reg_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              alu_req;
    logic              alu_dst_rd;
    logic [ADDR_W-1:0] alu_rt;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ack;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_rt;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ack;
    logic              link_req;
    logic              link_sel;
    logic [DATA_W-1:0] link_data;
    logic              link_ack;
    logic [1:0]        RegDst;
    logic [ADDR_W-1:0] reg_waddr;
    logic [DATA_W-1:0] reg_wdata;
    logic              RegWrite;
    logic              busy;

    int checks;
    int errors;

    reg_wb_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_req    (alu_req),
        .alu_dst_rd (alu_dst_rd),
        .alu_rt     (alu_rt),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ack    (alu_ack),
        .mem_req    (mem_req),
        .mem_rt     (mem_rt),
        .mem_data   (mem_data),
        .mem_ack    (mem_ack),
        .link_req   (link_req),
        .link_sel   (link_sel),
        .link_data  (link_data),
        .link_ack   (link_ack),
        .RegDst     (RegDst),
        .reg_waddr  (reg_waddr),
        .reg_wdata  (reg_wdata),
        .RegWrite   (RegWrite),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One single-requester transaction and its expected write-port values.
    // e_ack is {link, mem, alu}.
    typedef struct {
        logic        alu_req;
        logic        alu_dst_rd;
        logic [4:0]  alu_rt;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        mem_req;
        logic [4:0]  mem_rt;
        logic [31:0] mem_data;
        logic        link_req;
        logic        link_sel;
        logic [31:0] link_data;
        logic [1:0]  e_regdst;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_regwrite;
        logic [2:0]  e_ack;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one cycle; outputs are sampled and inputs driven 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alu_req    = 1'b0;
        alu_dst_rd = 1'b0;
        alu_rt     = '0;
        alu_rd     = '0;
        alu_data   = '0;
        mem_req    = 1'b0;
        mem_rt     = '0;
        mem_data   = '0;
        link_req   = 1'b0;
        link_sel   = 1'b0;
        link_data  = '0;
    endtask

    task automatic apply(input vec_t v);
        alu_req    = v.alu_req;
        alu_dst_rd = v.alu_dst_rd;
        alu_rt     = v.alu_rt;
        alu_rd     = v.alu_rd;
        alu_data   = v.alu_data;
        mem_req    = v.mem_req;
        mem_rt     = v.mem_rt;
        mem_data   = v.mem_data;
        link_req   = v.link_req;
        link_sel   = v.link_sel;
        link_data  = v.link_data;
    endtask

    function automatic logic [2:0] acks();
        return {link_ack, mem_ack, alu_ack};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " RegDst"},    64'(RegDst),    64'd0);
        check({tag, " reg_waddr"}, 64'(reg_waddr), 64'd0);
        check({tag, " reg_wdata"}, 64'(reg_wdata), 64'd0);
        check({tag, " RegWrite"},  64'(RegWrite),  64'd0);
        check({tag, " acks"},      64'(acks()),    64'd0);
        check({tag, " busy"},      64'(busy),      64'd0);
    endtask

    initial begin
        logic [2:0]  exp_ack;
        logic [4:0]  exp_addr;
        logic        alu_turn;

        checks = 0;
        errors = 0;

        //       alu_req dst rt     rd     alu_data      mem_req rt   mem_data      link sel link_data    RegDst waddr  wdata         RegWr ack
        vecs[0] = '{1'b1, 1'b1, 5'd3,  5'd8,  32'h0000_00AA, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0,        2'b01, 5'd8,  32'h0000_00AA, 1'b1, 3'b001};
        vecs[1] = '{1'b1, 1'b0, 5'd17, 5'd9,  32'h1234_5678, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0,        2'b00, 5'd17, 32'h1234_5678, 1'b1, 3'b001};
        vecs[2] = '{1'b0, 1'b0, 5'd0,  5'd0,  32'h0,         1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,        2'b00, 5'd5,  32'hDEAD_BEEF, 1'b1, 3'b010};
        vecs[3] = '{1'b0, 1'b0, 5'd0,  5'd0,  32'h0,         1'b1, 5'd0, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'h0,        2'b00, 5'd0,  32'h0BAD_0BAD, 1'b0, 3'b010};
        vecs[4] = '{1'b0, 1'b0, 5'd0,  5'd0,  32'h0,         1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 32'h0040_0010, 2'b10, 5'd31, 32'h0040_0010, 1'b1, 3'b100};
        vecs[5] = '{1'b0, 1'b0, 5'd0,  5'd0,  32'h0,         1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'hCAFE_F00D, 2'b11, 5'd30, 32'hCAFE_F00D, 1'b1, 3'b100};
        vecs[6] = '{1'b1, 1'b1, 5'd4,  5'd0,  32'h5555_AAAA, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0,        2'b01, 5'd0,  32'h5555_AAAA, 1'b0, 3'b001};
        vecs[7] = '{1'b1, 1'b0, 5'd31, 5'd2,  32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0,        2'b00, 5'd31, 32'hFFFF_FFFF, 1'b1, 3'b001};

        // ---------------- reset ----------------
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();
        check_reset_outputs("idle after reset");

        // ---------------- vector table ----------------
        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i]);
            step();  // WRITE
            check($sformatf("v%0d WRITE RegDst", i),    64'(RegDst),    64'(vecs[i].e_regdst));
            check($sformatf("v%0d WRITE reg_waddr", i), 64'(reg_waddr), 64'(vecs[i].e_waddr));
            check($sformatf("v%0d WRITE reg_wdata", i), 64'(reg_wdata), 64'(vecs[i].e_wdata));
            check($sformatf("v%0d WRITE RegWrite", i),  64'(RegWrite),  64'(vecs[i].e_regwrite));
            check($sformatf("v%0d WRITE acks", i),      64'(acks()),    64'd0);
            check($sformatf("v%0d WRITE busy", i),      64'(busy),      64'd1);
            // Perturb fields while the request is still held: must not reach the outputs.
            alu_data  = ~alu_data;
            alu_rd    = alu_rd + 5'd1;
            alu_rt    = alu_rt + 5'd1;
            mem_data  = ~mem_data;
            mem_rt    = mem_rt + 5'd1;
            link_data = ~link_data;
            link_sel  = ~link_sel;
            step();  // ACK
            check($sformatf("v%0d ACK acks", i),      64'(acks()),    64'(vecs[i].e_ack));
            check($sformatf("v%0d ACK RegWrite", i),  64'(RegWrite),  64'd0);
            check($sformatf("v%0d ACK reg_waddr", i), 64'(reg_waddr), 64'(vecs[i].e_waddr));
            check($sformatf("v%0d ACK reg_wdata", i), 64'(reg_wdata), 64'(vecs[i].e_wdata));
            check($sformatf("v%0d ACK busy", i),      64'(busy),      64'd1);
            clear_inputs();
            step();  // IDLE
            check($sformatf("v%0d IDLE busy", i), 64'(busy),   64'd0);
            check($sformatf("v%0d IDLE acks", i), 64'(acks()), 64'd0);
        end

        // ---------------- LINK beats MEM, MEM served next round ----------------
        link_req  = 1'b1;
        link_sel  = 1'b0;
        link_data = 32'h0040_0010;
        mem_req   = 1'b1;
        mem_rt    = 5'd6;
        mem_data  = 32'h0000_0055;
        step();  // WRITE (link)
        check("prio WRITE RegDst",    64'(RegDst),    64'h2);
        check("prio WRITE reg_waddr", 64'(reg_waddr), 64'd31);
        check("prio WRITE reg_wdata", 64'(reg_wdata), 64'h0040_0010);
        step();  // ACK (link)
        check("prio ACK acks", 64'(acks()), 64'b100);
        link_req = 1'b0;
        step();  // IDLE, mem still pending
        check("prio IDLE busy", 64'(busy), 64'd0);
        step();  // WRITE (mem)
        check("prio2 WRITE RegDst",    64'(RegDst),    64'h0);
        check("prio2 WRITE reg_waddr", 64'(reg_waddr), 64'd6);
        check("prio2 WRITE reg_wdata", 64'(reg_wdata), 64'h55);
        check("prio2 WRITE RegWrite",  64'(RegWrite),  64'd1);
        step();  // ACK (mem)
        check("prio2 ACK acks", 64'(acks()), 64'b010);
        clear_inputs();
        step();

        // ---------------- ALU and MEM contending for 4 rounds ----------------
        // Reset first so the round-robin pointer starts at ALU.
        reset = 1'b1;
        step();
        reset = 1'b0;
        alu_req    = 1'b1;
        alu_dst_rd = 1'b1;
        alu_rd     = 5'd12;
        alu_data   = 32'hA1A1_A1A1;
        mem_req    = 1'b1;
        mem_rt     = 5'd13;
        mem_data   = 32'hB2B2_B2B2;
        alu_turn   = 1'b1;
        for (int r = 0; r < 4; r++) begin
`ifdef REG_WB_RR_EN
            exp_addr = alu_turn ? 5'd12 : 5'd13;
            exp_ack  = alu_turn ? 3'b001 : 3'b010;
            alu_turn = ~alu_turn;
`else
            exp_addr = 5'd13;
            exp_ack  = 3'b010;
`endif
            step();  // WRITE
            check($sformatf("rr%0d WRITE reg_waddr", r), 64'(reg_waddr), 64'(exp_addr));
            step();  // ACK
            check($sformatf("rr%0d ACK acks", r), 64'(acks()), 64'(exp_ack));
            step();  // IDLE (both requests still high)
        end
        clear_inputs();
        step();
        step();
        step();
        check("rr drained busy", 64'(busy), 64'd0);

        // ---------------- reset during WRITE of a link_sel=1 request ----------------
        link_req  = 1'b1;
        link_sel  = 1'b1;
        link_data = 32'h8000_0180;
        step();  // WRITE
        check("rst WRITE RegWrite", 64'(RegWrite), 64'd1);
        reset = 1'b1;
        step();  // reset sampled -> IDLE
        check_reset_outputs("rst in WRITE");
        reset = 1'b0;
        step();  // reissued request granted -> WRITE
        check("rst retry RegDst",    64'(RegDst),    64'h3);
        check("rst retry reg_waddr", 64'(reg_waddr), 64'd30);
        check("rst retry reg_wdata", 64'(reg_wdata), 64'h8000_0180);
        check("rst retry RegWrite",  64'(RegWrite),  64'd1);
        step();  // ACK
        check("rst retry ACK acks", 64'(acks()), 64'b100);
        clear_inputs();
        step();
        check("final idle busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
